// File: rtl/inst_queue_pkg.sv
// Shared types and helpers for the fetch/decode instruction queue.
// The leading-ones counter is also used by decode for issue counting.
package inst_queue_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef struct packed {
    virt_t   pc;
    uint32_t inst;
    logic    iaddr_ex;
  } inst_queue_entry_t;

  localparam int LO_MAX_W = 16;

  // Length of the unbroken run of ones starting at bit 0, limited to the low w bits.
  function automatic int lead_ones(input logic [LO_MAX_W-1:0] v, input int w);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < LO_MAX_W; i++) begin
      if (run && i < w) begin
        if (v[i]) n++;
        else      run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Multi-slot instruction queue between fetch and decode: up to N_FETCH pushes
// and N_ISSUE pops per cycle, flushed on exception or branch redirect.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int N_FETCH = 2,
  parameter int N_ISSUE = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [N_FETCH-1:0]                  push_valid,
  input  inst_queue_entry_t [N_FETCH-1:0]     push_data,
  output logic                                push_ready,
  output logic [N_ISSUE-1:0]                  pop_valid,
  output inst_queue_entry_t [N_ISSUE-1:0]     pop_data,
  input  logic [$clog2(N_ISSUE+1)-1:0]        pop_count,
  output logic [$clog2(DEPTH+1)-1:0]          count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  inst_queue_entry_t mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     n_lead, n_push, n_pop, n_avail, pop_req;

  // Ready looks only at current occupancy; a same-cycle pop is not credited.
  assign push_ready = (count_q <= CW'(DEPTH - N_FETCH));
  assign n_lead     = CW'(lead_ones(LO_MAX_W'(push_valid), N_FETCH));
  assign n_push     = push_ready ? n_lead : '0;

  assign n_avail = (count_q > CW'(N_ISSUE)) ? CW'(N_ISSUE) : count_q;
  assign pop_req = CW'(pop_count);
  assign n_pop   = (pop_req > n_avail) ? n_avail : pop_req;

  always_comb begin
    head_d  = head_q + PW'(n_pop);
    tail_d  = tail_q + PW'(n_push);
    count_d = count_q + n_push - n_pop;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; pointer arithmetic wraps naturally at power-of-two DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_FETCH; i++) begin
      if (!rst && !flush && (CW'(i) < n_push))
        mem_q[tail_q + PW'(i)] <= push_data[i];
    end
  end

  for (genvar g = 0; g < N_ISSUE; g++) begin : g_pop
    assign pop_valid[g] = (count_q > CW'(g));
    assign pop_data[g]  = pop_valid[g] ? mem_q[head_q + PW'(g)] : '0;
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with DEPTH=8, N_FETCH=2, N_ISSUE=2.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic                          clk;
  logic                          rst;
  logic                          flush;
  logic [1:0]                    push_valid;
  inst_queue_entry_t [1:0]       push_data;
  logic                          push_ready;
  logic [1:0]                    pop_valid;
  inst_queue_entry_t [1:0]       pop_data;
  logic [1:0]                    pop_count;
  logic [3:0]                    count;

  int errors = 0;
  int checks = 0;
  int proto_err = 0;

  inst_queue #(.DEPTH(8), .N_FETCH(2), .N_ISSUE(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_count(pop_count),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode protocol monitor: popping more than the presented entries is an error.
  always @(posedge clk) begin
    if (!rst) begin
      assert (int'(pop_count) <= ((count > 4'd2) ? 2 : int'(count)))
      else proto_err++;
    end
  end

  function automatic inst_queue_entry_t mk(input int k);
    inst_queue_entry_t e;
    e.pc       = 32'h0000_1000 + 32'(k) * 4;
    e.inst     = 32'hA500_0000 + 32'(k);
    e.iaddr_ex = k[0];
    return e;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    flush      = 1'b0;
    push_valid = 2'b00;
    pop_count  = 2'd0;
    push_data  = '0;
  endtask

  task automatic push(input logic [1:0] v, input int k);
    push_valid   = v;
    push_data[0] = mk(k);
    push_data[1] = mk(k + 1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    step(); step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (pop_valid !== 2'b00) begin errors++; $display("FAIL reset_pop_valid got %b want 00", pop_valid); end
    checks++; if (pop_data !== '0) begin errors++; $display("FAIL reset_pop_data got %h want 0", pop_data); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
    rst = 1'b0;
  endtask

  task automatic test_push2;
    inst_queue_entry_t e0, e1;
    e0 = '0; e0.pc = 32'hbfc0_0000; e0.inst = 32'h1234_5678;
    e1 = '0; e1.pc = 32'hbfc0_0004; e1.inst = 32'h9abc_def0; e1.iaddr_ex = 1'b1;
    push_valid = 2'b11; push_data[0] = e0; push_data[1] = e1;
    step();
    idle();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL push2_count got %0d want 2", count); end
    checks++; if (pop_valid !== 2'b11) begin errors++; $display("FAIL push2_pop_valid got %b want 11", pop_valid); end
    checks++; if (pop_data[0] !== e0) begin errors++; $display("FAIL push2_data0 got %h want %h", pop_data[0], e0); end
    checks++; if (pop_data[1] !== e1) begin errors++; $display("FAIL push2_data1 got %h want %h", pop_data[1], e1); end
    pop_count = 2'd2;
    step();
    idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL push2_drain got %0d want 0", count); end
  endtask

  // Fill to 7, refused push with pop, then a push straddling slot 7 -> 0.
  task automatic test_fill_wrap;
    flush = 1'b1; step(); idle();
    for (int c = 0; c < 3; c++) begin push(2'b11, 100 + 2*c); step(); end
    push(2'b01, 106); step(); idle();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL fill_count got %0d want 7", count); end
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", push_ready); end
    push(2'b11, 200); pop_count = 2'd1; step(); idle();
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL full_push_count got %0d want 6", count); end
    checks++; if (pop_data[0] !== mk(101)) begin errors++; $display("FAIL full_head got %h want %h", pop_data[0], mk(101)); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL ready6 got %b want 1", push_ready); end
    push(2'b11, 107); step(); idle();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL wrap_count got %0d want 8", count); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (pop_data[0] !== mk(101 + 2*p)) begin errors++; $display("FAIL wrap_pop%0d_d0 got %h want %h", p, pop_data[0], mk(101 + 2*p)); end
      checks++; if (pop_data[1] !== mk(102 + 2*p)) begin errors++; $display("FAIL wrap_pop%0d_d1 got %h want %h", p, pop_data[1], mk(102 + 2*p)); end
      pop_count = 2'd2; step(); idle();
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_drain got %0d want 0", count); end
  endtask

  task automatic test_push_pop_same;
    push(2'b11, 20); step();
    push(2'b01, 22); step(); idle();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL pp_pre got %0d want 3", count); end
    push(2'b11, 23); pop_count = 2'd1; step(); idle();
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL pp_count got %0d want 4", count); end
    checks++; if (pop_data[0] !== mk(21)) begin errors++; $display("FAIL pp_d0 got %h want %h", pop_data[0], mk(21)); end
    checks++; if (pop_data[1] !== mk(22)) begin errors++; $display("FAIL pp_d1 got %h want %h", pop_data[1], mk(22)); end
  endtask

  task automatic test_partial_valid;
    push(2'b10, 90); step(); idle();
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL pv10_count got %0d want 4", count); end
    push(2'b01, 30); step(); idle();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL pv01_count got %0d want 5", count); end
    pop_count = 2'd2; step();
    pop_count = 2'd2; step(); idle();
    checks++; if (pop_valid !== 2'b01) begin errors++; $display("FAIL pv_pop_valid got %b want 01", pop_valid); end
    checks++; if (pop_data[0] !== mk(30)) begin errors++; $display("FAIL pv_d0 got %h want %h", pop_data[0], mk(30)); end
    checks++; if (pop_data[1] !== '0) begin errors++; $display("FAIL pv_d1_zero got %h want 0", pop_data[1]); end
  endtask

  task automatic test_clamp;
    int pe0;
    pe0 = proto_err;
    pop_count = 2'd2; step(); idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL clamp_count got %0d want 0", count); end
    checks++; if (proto_err - pe0 !== 1) begin errors++; $display("FAIL clamp_assert got %0d want 1", proto_err - pe0); end
  endtask

  task automatic test_flush;
    push(2'b11, 40); step();
    push(2'b11, 42); step();
    push(2'b01, 44); step(); idle();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d want 5", count); end
    flush = 1'b1; push(2'b11, 50); pop_count = 2'd2; step(); idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
    checks++; if (pop_valid !== 2'b00) begin errors++; $display("FAIL flush_pop_valid got %b want 00", pop_valid); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", push_ready); end
    checks++; if (pop_data !== '0) begin errors++; $display("FAIL flush_data got %h want 0", pop_data); end
    push(2'b11, 60); step(); idle();
    checks++; if (pop_data[0] !== mk(60)) begin errors++; $display("FAIL postflush_d0 got %h want %h", pop_data[0], mk(60)); end
    checks++; if (pop_data[1] !== mk(61)) begin errors++; $display("FAIL postflush_d1 got %h want %h", pop_data[1], mk(61)); end
  endtask

  task automatic test_rst_priority;
    rst = 1'b1; flush = 1'b1; push(2'b11, 80); step();
    rst = 1'b0; idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_flush_count got %0d want 0", count); end
    checks++; if (pop_valid !== 2'b00) begin errors++; $display("FAIL rst_flush_valid got %b want 00", pop_valid); end
    push(2'b11, 70); step(); idle();
    checks++; if (pop_data[0] !== mk(70)) begin errors++; $display("FAIL rst_after_d0 got %h want %h", pop_data[0], mk(70)); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_push2();
    test_fill_wrap();
    test_push_pop_same();
    test_partial_valid();
    test_clamp();
    test_flush();
    test_rst_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
